// File: rtl/rv32i_pkg.sv
// Shared widths, ALU opcode encoding and small helpers for the RV32I execute/memory datapath.
package rv32i_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DM_WORDS = 32;
    localparam int unsigned DM_AW    = $clog2(DM_WORDS);
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned OP_W     = 5;
    localparam int unsigned TIM_W    = 16;

    typedef enum logic [OP_W-1:0] {
        AluAdd   = 5'd0,
        AluSub   = 5'd1,
        AluSll   = 5'd2,
        AluSlt   = 5'd3,
        AluSltu  = 5'd4,
        AluXor   = 5'd5,
        AluSrl   = 5'd6,
        AluSra   = 5'd7,
        AluOr    = 5'd8,
        AluAnd   = 5'd9,
        AluEq    = 5'd10,
        AluNe    = 5'd11,
        AluGe    = 5'd12,
        AluLt    = 5'd13,
        AluPassB = 5'd14
    } alu_op_e;

    // Compare ops return a full-width 0/1 so the flag logic can test result==1.
    function automatic logic [XLEN-1:0] bool_to_word(input logic b);
        return {{(XLEN-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/rv32i_exec_datapath_alu.sv
// Combinational 32-bit ALU; unknown opcodes produce zero.
module rv32i_exec_datapath_alu
    import rv32i_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      shamt_i,
    output logic [XLEN-1:0] result_o
);

    alu_op_e op;
    assign op = alu_op_e'(op_i);

    always_comb begin
        result_o = '0;
        case (op)
            AluAdd:   result_o = a_i + b_i;
            AluSub:   result_o = a_i - b_i;
            AluSll:   result_o = a_i << shamt_i;
            AluSlt:   result_o = bool_to_word($signed(a_i) < $signed(b_i));
            AluSltu:  result_o = bool_to_word(a_i < b_i);
            AluXor:   result_o = a_i ^ b_i;
            AluSrl:   result_o = a_i >> shamt_i;
            AluSra:   result_o = $unsigned($signed(a_i) >>> shamt_i);
            AluOr:    result_o = a_i | b_i;
            AluAnd:   result_o = a_i & b_i;
            AluEq:    result_o = bool_to_word(a_i == b_i);
            AluNe:    result_o = bool_to_word(a_i != b_i);
            AluGe:    result_o = bool_to_word($signed(a_i) >= $signed(b_i));
            AluLt:    result_o = bool_to_word($signed(a_i) < $signed(b_i));
            AluPassB: result_o = b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_exec_datapath_data_memory.sv
// Word-addressed data memory with combinational read and clocked write.
module rv32i_exec_datapath_data_memory
    import rv32i_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DM_AW-1:0] raddr_i,
    output logic [XLEN-1:0]  rdata_o,
    input  logic             we_i,
    input  logic [DM_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]  wdata_i
);

    logic [XLEN-1:0] mem_q [DM_WORDS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rv32i_exec_datapath_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero.
module rv32i_exec_datapath_regfile
    import rv32i_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the old contents.
    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/rv32i_exec_datapath.sv
// Execute/memory datapath: regfile, ALU, data memory, writeback mux, store stall and timer config.
module rv32i_exec_datapath
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] read_reg_num1,
    input  logic [REG_AW-1:0] read_reg_num2,
    input  logic [REG_AW-1:0] write_reg_num,
    input  logic              reg_write,
    input  logic [5:0]        alu_cntrl,
    input  logic [XLEN-1:0]   imm_val,
    input  logic [4:0]        shamt,
    input  logic [11:0]       offset,
    input  logic              lb,
    input  logic              sw,
    input  logic              mem_to_reg,
    input  logic              lui_cntrl,
    input  logic [XLEN-1:0]   imm_val_lui,
    input  logic              jump,
    input  logic [XLEN-1:0]   return_address,
    input  logic              beq_cntrl,
    input  logic              bneq_cntrl,
    input  logic              bgeq_cntrl,
    input  logic              blt_cntrl,
    input  logic              timer_en,
    input  logic              timer_reg_en,
    output logic [XLEN-1:0]   write_data_alu,
    output logic              beq,
    output logic              bneq,
    output logic              bge,
    output logic              blt,
    output logic              stall,
    output logic [TIM_W-1:0]  TIM_PSC,
    output logic [TIM_W-1:0]  TIM_ARR
);

    logic [XLEN-1:0]  rs1, rs2, alu_b, alu_result, mem_rdata, wb_data;
    logic [4:0]       alu_shamt;
    logic [DM_AW-1:0] mem_addr;
    logic             res_is_one;

    logic [DM_AW-1:0] st_addr_q;
    logic [XLEN-1:0]  st_data_q;
    logic             stall_q;
    logic [TIM_W-1:0] psc_q, arr_q;

    rv32i_exec_datapath_regfile u_regfile (
        .clk_i    (clk),
        .rst_ni   (reset),
        .raddr1_i (read_reg_num1),
        .raddr2_i (read_reg_num2),
        .rdata1_o (rs1),
        .rdata2_o (rs2),
        .we_i     (reg_write),
        .waddr_i  (write_reg_num),
        .wdata_i  (wb_data)
    );

    assign alu_b     = alu_cntrl[5] ? imm_val : rs2;
    assign alu_shamt = alu_cntrl[5] ? shamt : rs2[4:0];

    rv32i_exec_datapath_alu u_alu (
        .op_i     (alu_cntrl[4:0]),
        .a_i      (rs1),
        .b_i      (alu_b),
        .shamt_i  (alu_shamt),
        .result_o (alu_result)
    );

    // Only the low address bits matter, so the sign-extended add is done at that width.
    assign mem_addr = rs1[DM_AW-1:0] + offset[DM_AW-1:0];

    rv32i_exec_datapath_data_memory u_dmem (
        .clk_i   (clk),
        .rst_ni  (reset),
        .raddr_i (mem_addr),
        .rdata_o (mem_rdata),
        .we_i    (stall_q),
        .waddr_i (st_addr_q),
        .wdata_i (st_data_q)
    );

    always_comb begin
        wb_data = alu_result;
        if (jump) begin
            wb_data = return_address;
        end else if (lui_cntrl) begin
            wb_data = imm_val_lui;
        end else if (mem_to_reg || lb) begin
            wb_data = mem_rdata;
        end
    end

    // Store latches in the sw cycle and commits at the end of the following stall cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_addr_q <= '0;
            st_data_q <= '0;
            stall_q   <= 1'b0;
        end else begin
            stall_q <= sw;
            if (sw) begin
                st_addr_q <= mem_addr;
                st_data_q <= rs2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= '0;
            arr_q <= '0;
        end else if (timer_en && timer_reg_en) begin
            if (alu_result == 32'd1) begin
                psc_q <= rs1[TIM_W-1:0];
            end else if (alu_result == 32'd2) begin
                arr_q <= rs1[TIM_W-1:0];
            end
        end
    end

    assign res_is_one     = (alu_result == 32'd1);
    assign write_data_alu = alu_result;
    assign beq            = beq_cntrl & res_is_one;
    assign bneq           = bneq_cntrl & res_is_one;
    assign bge            = bgeq_cntrl & res_is_one;
    assign blt            = blt_cntrl & res_is_one;
    assign stall          = stall_q;
    assign TIM_PSC        = psc_q;
    assign TIM_ARR        = arr_q;

endmodule

// File: tb/tb_rv32i_exec_datapath.sv
// Directed-vector bench: the driver queues expected values, a negedge monitor pops and compares.
module tb_rv32i_exec_datapath;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg_num, shamt;
    logic        reg_write, lb, sw, mem_to_reg, lui_cntrl, jump;
    logic [5:0]  alu_cntrl;
    logic [31:0] imm_val, imm_val_lui, return_address;
    logic [11:0] offset;
    logic        beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl, timer_en, timer_reg_en;
    logic [31:0] write_data_alu;
    logic        beq, bneq, bge, blt, stall;
    logic [15:0] TIM_PSC, TIM_ARR;

    typedef enum {KRes, KStall, KPsc, KArr, KFlags} chk_e;
    typedef struct {
        chk_e        kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rv32i_exec_datapath dut (
        .clk            (clk),
        .reset          (rst_n),
        .read_reg_num1  (read_reg_num1),
        .read_reg_num2  (read_reg_num2),
        .write_reg_num  (write_reg_num),
        .reg_write      (reg_write),
        .alu_cntrl      (alu_cntrl),
        .imm_val        (imm_val),
        .shamt          (shamt),
        .offset         (offset),
        .lb             (lb),
        .sw             (sw),
        .mem_to_reg     (mem_to_reg),
        .lui_cntrl      (lui_cntrl),
        .imm_val_lui    (imm_val_lui),
        .jump           (jump),
        .return_address (return_address),
        .beq_cntrl      (beq_cntrl),
        .bneq_cntrl     (bneq_cntrl),
        .bgeq_cntrl     (bgeq_cntrl),
        .blt_cntrl      (blt_cntrl),
        .timer_en       (timer_en),
        .timer_reg_en   (timer_reg_en),
        .write_data_alu (write_data_alu),
        .beq            (beq),
        .bneq           (bneq),
        .bge            (bge),
        .blt            (blt),
        .stall          (stall),
        .TIM_PSC        (TIM_PSC),
        .TIM_ARR        (TIM_ARR)
    );

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                KRes:    act = write_data_alu;
                KStall:  act = {31'd0, stall};
                KPsc:    act = {16'd0, TIM_PSC};
                KArr:    act = {16'd0, TIM_ARR};
                default: act = {28'd0, beq, bneq, bge, blt};
            endcase
            n_vec++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic clear_ctl();
        read_reg_num1 = '0; read_reg_num2 = '0; write_reg_num = '0; shamt = '0;
        reg_write = 0; lb = 0; sw = 0; mem_to_reg = 0; lui_cntrl = 0; jump = 0;
        alu_cntrl = '0; imm_val = '0; imm_val_lui = '0; return_address = '0; offset = '0;
        beq_cntrl = 0; bneq_cntrl = 0; bgeq_cntrl = 0; blt_cntrl = 0;
        timer_en = 0; timer_reg_en = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctl();
    endtask

    task automatic expect_v(input chk_e k, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = k; e.exp = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic alu_rr(input alu_op_e op, input logic [4:0] r1, input logic [4:0] r2);
        read_reg_num1 = r1; read_reg_num2 = r2; alu_cntrl = {1'b0, op};
    endtask

    task automatic alu_ri(input alu_op_e op, input logic [4:0] r1, input logic [31:0] imm);
        read_reg_num1 = r1; imm_val = imm; alu_cntrl = {1'b1, op};
    endtask

    task automatic wr_imm(input logic [4:0] rd, input logic [31:0] v);
        alu_ri(AluAdd, 5'd0, v); reg_write = 1; write_reg_num = rd;
    endtask

    task automatic chk_reg(input logic [4:0] r, input logic [31:0] v, input string nm);
        alu_rr(AluAdd, r, 5'd0);
        expect_v(KRes, v, nm);
    endtask

    task automatic load(input logic [4:0] r1, input logic [11:0] off, input logic [4:0] rd);
        lb = 1; read_reg_num1 = r1; offset = off; reg_write = 1; write_reg_num = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_ctl();
        repeat (2) @(posedge clk);
        #1;
        expect_v(KStall, 0, "rst_stall"); expect_v(KPsc, 0, "rst_psc"); expect_v(KArr, 0, "rst_arr");
        tick();
        rst_n = 1'b1;
        expect_v(KStall, 0, "post_rst_stall"); expect_v(KPsc, 0, "post_rst_psc");
        tick();
        for (int r = 1; r < 32; r++) begin
            chk_reg(5'(r), 0, "rst_reg");
            tick();
        end

        wr_imm(5'd1, 32'd5); expect_v(KRes, 32'd5, "wr_x1"); tick();
        lui_cntrl = 1; imm_val_lui = 32'd3; reg_write = 1; write_reg_num = 5'd2; tick();
        lui_cntrl = 1; imm_val_lui = 32'h8000_0000; reg_write = 1; write_reg_num = 5'd3; tick();
        alu_rr(AluAdd, 1, 2);  expect_v(KRes, 32'd8, "add");           tick();
        alu_rr(AluSub, 1, 2);  expect_v(KRes, 32'd2, "sub");           tick();
        alu_rr(AluSub, 2, 1);  expect_v(KRes, 32'hFFFF_FFFE, "sub_wrap"); tick();
        alu_rr(AluSlt, 2, 1);  expect_v(KRes, 32'd1, "slt");           tick();
        alu_rr(AluSlt, 3, 1);  expect_v(KRes, 32'd1, "slt_neg");       tick();
        alu_rr(AluSltu, 3, 1); expect_v(KRes, 32'd0, "sltu_big");      tick();
        alu_rr(AluSltu, 1, 3); expect_v(KRes, 32'd1, "sltu");          tick();
        alu_ri(AluSra, 3, 0); shamt = 5'd4; expect_v(KRes, 32'hF800_0000, "sra"); tick();
        alu_ri(AluSrl, 3, 0); shamt = 5'd4; expect_v(KRes, 32'h0800_0000, "srl"); tick();
        alu_rr(AluSll, 1, 2);  expect_v(KRes, 32'h28, "sll_reg");      tick();
        alu_rr(AluXor, 1, 2);  expect_v(KRes, 32'd6, "xor");           tick();
        alu_rr(AluOr, 1, 2);   expect_v(KRes, 32'd7, "or");            tick();
        alu_rr(AluAnd, 1, 2);  expect_v(KRes, 32'd1, "and");           tick();
        alu_ri(AluPassB, 1, 32'hCAFE_0000); expect_v(KRes, 32'hCAFE_0000, "pass_b"); tick();
        read_reg_num1 = 1; read_reg_num2 = 2; alu_cntrl = 6'd15;
        expect_v(KRes, 32'd0, "bad_op"); tick();

        wr_imm(5'd0, 32'hDEAD); tick();
        chk_reg(5'd0, 0, "x0_stays_zero"); tick();
        alu_rr(AluAdd, 0, 1); expect_v(KRes, 32'd5, "add_x0"); tick();
        jump = 1; lui_cntrl = 1; return_address = 32'h100; imm_val_lui = 32'h5000;
        reg_write = 1; write_reg_num = 5'd9; tick();
        chk_reg(5'd9, 32'h100, "jump_prio"); tick();

        wr_imm(5'd4, 32'h1234); tick();
        sw = 1; read_reg_num1 = 1; read_reg_num2 = 4; offset = 12'd3;
        expect_v(KStall, 0, "sw_cycle_stall"); tick();
        load(5'd0, 12'd8, 5'd5); expect_v(KStall, 1, "stall_cycle"); tick();
        load(5'd0, 12'd8, 5'd6); expect_v(KStall, 0, "stall_done"); tick();
        chk_reg(5'd5, 0, "ld_pre_store"); tick();
        chk_reg(5'd6, 32'h1234, "ld_after_store"); tick();
        read_reg_num1 = 4; offset = 12'hFF4; mem_to_reg = 1; reg_write = 1; write_reg_num = 5'd7;
        tick();
        chk_reg(5'd7, 32'h1234, "ld_wrap_neg_off"); tick();

        sw = 1; read_reg_num1 = 0; read_reg_num2 = 1; offset = 12'd10;
        expect_v(KStall, 0, "b2b_0"); tick();
        sw = 1; read_reg_num1 = 0; read_reg_num2 = 2; offset = 12'd11;
        expect_v(KStall, 1, "b2b_1"); tick();
        expect_v(KStall, 1, "b2b_2"); tick();
        expect_v(KStall, 0, "b2b_3"); tick();
        load(5'd0, 12'd10, 5'd10); tick();
        load(5'd0, 12'd11, 5'd11); tick();
        chk_reg(5'd10, 32'd5, "b2b_mem10"); tick();
        chk_reg(5'd11, 32'd3, "b2b_mem11"); tick();

        alu_rr(AluEq, 1, 1); beq_cntrl = 1;
        expect_v(KRes, 32'd1, "eq"); expect_v(KFlags, 4'b1000, "beq_flag"); tick();
        alu_rr(AluNe, 1, 2); expect_v(KFlags, 4'b0000, "bneq_off"); tick();
        alu_rr(AluNe, 1, 2); bneq_cntrl = 1; expect_v(KFlags, 4'b0100, "bneq_on"); tick();
        alu_rr(AluGe, 3, 1); bgeq_cntrl = 1; expect_v(KFlags, 4'b0000, "bge_false"); tick();
        alu_rr(AluGe, 1, 3); bgeq_cntrl = 1; expect_v(KFlags, 4'b0010, "bge_true"); tick();
        alu_rr(AluLt, 3, 1); blt_cntrl = 1; expect_v(KFlags, 4'b0001, "blt_true"); tick();

        wr_imm(5'd8, 32'h00FF); tick();
        timer_en = 1; timer_reg_en = 1; alu_ri(AluPassB, 8, 32'd1); tick();
        expect_v(KPsc, 32'h00FF, "psc_set"); expect_v(KArr, 0, "arr_untouched"); tick();
        timer_en = 1; timer_reg_en = 1; alu_ri(AluPassB, 4, 32'd2); tick();
        expect_v(KArr, 32'h1234, "arr_set"); expect_v(KPsc, 32'h00FF, "psc_hold"); tick();
        timer_en = 1; timer_reg_en = 0; alu_ri(AluPassB, 1, 32'd1); tick();
        timer_en = 1; timer_reg_en = 1; alu_ri(AluPassB, 1, 32'd3); tick();
        expect_v(KPsc, 32'h00FF, "psc_no_en"); expect_v(KArr, 32'h1234, "arr_other_res"); tick();

        sw = 1; read_reg_num1 = 0; read_reg_num2 = 4; offset = 12'd20; tick();
        expect_v(KStall, 1, "stall_before_rst");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        tick();
        expect_v(KStall, 0, "rst_mid_stall"); expect_v(KPsc, 0, "rst_psc2"); tick();
        rst_n = 1'b1;
        load(5'd0, 12'd20, 5'd1); tick();
        chk_reg(5'd1, 0, "store_discarded"); tick();
        chk_reg(5'd4, 0, "reg_cleared"); tick();
        tick();
        tick();
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
